// File: rtl/rf_wb_scheduler_pkg.sv
// rf_sched_pkg: shared constants and types for the register-file writeback
// scheduler.
//   DATA_W / ADDR_W / NREGS : register file geometry (NREGS == 2**ADDR_W)
//   req_sel_e               : identifies a writeback requester (ALU or MEM)
//   wb_req_t                : one writeback request (valid, address, data)
package rf_sched_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_sel_e;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// rf_wb_scheduler_if: bundles every bus signal of the writeback scheduler.
//   master modport : the execute/memory stages and decode
//                    (drive requests and issue information, see ready/stall/rf/busy)
//   slave modport  : the scheduler itself
//   alu_* / mem_*  : two writeback req/addr/data/ready handshakes
//   issue_*        : decode issue request and the operand registers it uses
//   stall          : issue blocked this cycle
//   rf_*           : register file write port
//   busy_vec       : pending-write scoreboard
interface rf_wb_scheduler_if;
    import rf_sched_pkg::*;

    logic              alu_req;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              issue_valid;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_dst;
    logic [ADDR_W-1:0] issue_src1;
    logic [ADDR_W-1:0] issue_src2;
    logic              stall;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREGS-1:0]  busy_vec;

    modport master (
        output alu_req, alu_addr, alu_data,
        output mem_req, mem_addr, mem_data,
        output issue_valid, issue_wr, issue_dst, issue_src1, issue_src2,
        input  alu_ready, mem_ready, stall,
        input  rf_we, rf_waddr, rf_wdata, busy_vec
    );

    modport slave (
        input  alu_req, alu_addr, alu_data,
        input  mem_req, mem_addr, mem_data,
        input  issue_valid, issue_wr, issue_dst, issue_src1, issue_src2,
        output alu_ready, mem_ready, stall,
        output rf_we, rf_waddr, rf_wdata, busy_vec
    );

endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// rf_scoreboard: busy bit per register with a pending writeback, plus the
// RAW/WAW stall check for the instruction trying to issue.
//   clk, reset        : clock, synchronous active-high reset
//   issue_*           : decode issue request and its registers
//   grant_valid/addr  : writeback granted this cycle and its destination
//   stall             : issue blocked this cycle
//   busy_vec          : registered scoreboard
// Optional macro RF_EARLY_RELEASE_EN: the register being granted this cycle
// is already treated as free by the stall check, because the register file
// write lands before the issuing instruction reads its operands.
module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_src1,
    input  logic [ADDR_W-1:0] issue_src2,
    input  logic              grant_valid,
    input  logic [ADDR_W-1:0] grant_addr,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] grant_mask;
    logic [NREGS-1:0] check_busy;
    logic             issue_fire;

    always_comb begin
        grant_mask = '0;
        if (grant_valid) begin
            grant_mask[grant_addr] = 1'b1;
        end

`ifdef RF_EARLY_RELEASE_EN
        check_busy = busy_q & ~grant_mask;
`else
        check_busy = busy_q;
`endif

        stall = ~reset & issue_valid &
                (check_busy[issue_src1] | check_busy[issue_src2] |
                 (issue_wr & check_busy[issue_dst]));

        issue_fire = issue_valid & issue_wr & ~stall;

        // Clear first, then set: a newer write to the same register that
        // issues in the grant cycle must leave the register marked busy.
        busy_d = busy_q & ~grant_mask;
        if (issue_fire) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the single register-file write port between the
// ALU and the load unit with round-robin arbitration, registers the write
// port (one cycle latency) and keeps the pending-write scoreboard that
// stalls issue on RAW/WAW hazards.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : rf_wb_scheduler_if slave modport (requests, issue, rf port, busy)
// Optional macro RF_EARLY_RELEASE_EN (handled in rf_scoreboard): lets a
// dependent instruction issue in the same cycle its producer is granted.
module rf_wb_scheduler
    import rf_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    rf_wb_scheduler_if.slave bus
);

    wb_req_t           alu_wb, mem_wb;
    req_sel_e          last_grant_q, last_grant_d;
    logic              alu_grant, mem_grant, grant_valid;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign alu_wb = '{req: bus.alu_req, addr: bus.alu_addr, data: bus.alu_data};
    assign mem_wb = '{req: bus.mem_req, addr: bus.mem_addr, data: bus.mem_data};

    // Round-robin: on contention the requester that did not win last time
    // gets the port. Reset suppresses every grant.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!reset) begin
            if (alu_wb.req && mem_wb.req) begin
                if (last_grant_q == REQ_MEM) begin
                    alu_grant = 1'b1;
                end else begin
                    mem_grant = 1'b1;
                end
            end else begin
                alu_grant = alu_wb.req;
                mem_grant = mem_wb.req;
            end
        end
        grant_valid = alu_grant | mem_grant;
        grant_addr  = mem_grant ? mem_wb.addr : alu_wb.addr;
        grant_data  = mem_grant ? mem_wb.data : alu_wb.data;
    end

    // Without a grant the address/data registers keep their old contents.
    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_grant) begin
            last_grant_d = REQ_ALU;
        end else if (mem_grant) begin
            last_grant_d = REQ_MEM;
        end
        rf_we_d    = grant_valid;
        rf_waddr_d = grant_valid ? grant_addr : rf_waddr_q;
        rf_wdata_d = grant_valid ? grant_data : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_MEM;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_wr    (bus.issue_wr),
        .issue_dst   (bus.issue_dst),
        .issue_src1  (bus.issue_src1),
        .issue_src2  (bus.issue_src2),
        .grant_valid (grant_valid),
        .grant_addr  (grant_addr),
        .stall       (bus.stall),
        .busy_vec    (bus.busy_vec)
    );

    assign bus.alu_ready = alu_grant;
    assign bus.mem_ready = mem_grant;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and randomized stimulus for rf_wb_scheduler,
// checked against a cycle-level behavioural model of the scheduler's rules.
module tb_rf_wb_scheduler;
    import rf_sched_pkg::*;

    typedef struct {
        logic        rst;
        logic        areq;
        logic [2:0]  aaddr;
        logic [15:0] adata;
        logic        mreq;
        logic [2:0]  maddr;
        logic [15:0] mdata;
        logic        iv;
        logic        iw;
        logic [2:0]  idst;
        logic [2:0]  is1;
        logic [2:0]  is2;
    } stim_t;

`ifdef RF_EARLY_RELEASE_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_scheduler_if bus();

    rf_wb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_busy;
    logic        m_last_mem;
    logic        m_we;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;
    logic        m_agrant, m_mgrant, m_stall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.areq = 1'b0; s.aaddr = 3'd0; s.adata = 16'h0;
        s.mreq = 1'b0; s.maddr = 3'd0; s.mdata = 16'h0;
        s.iv = 1'b0; s.iw = 1'b0; s.idst = 3'd0; s.is1 = 3'd0; s.is2 = 3'd0;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        reset           = s.rst;
        bus.alu_req     = s.areq;
        bus.alu_addr    = s.aaddr;
        bus.alu_data    = s.adata;
        bus.mem_req     = s.mreq;
        bus.mem_addr    = s.maddr;
        bus.mem_data    = s.mdata;
        bus.issue_valid = s.iv;
        bus.issue_wr    = s.iw;
        bus.issue_dst   = s.idst;
        bus.issue_src1  = s.is1;
        bus.issue_src2  = s.is2;
    endtask

    // One clock cycle: check registered outputs, drive new inputs, check the
    // combinational outputs, then advance the model to the next cycle.
    task automatic stepCycle(input stim_t s);
        logic        win_alu, win_mem;
        logic [2:0]  ga;
        logic [15:0] gd;
        logic [7:0]  eff;
        @(negedge clk);
        checkOutput("rf_we",    32'(bus.rf_we),    32'(m_we));
        checkOutput("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
        checkOutput("rf_wdata", 32'(bus.rf_wdata), 32'(m_wdata));
        checkOutput("busy_vec", 32'(bus.busy_vec), 32'(m_busy));
        applyStimulus(s);
        #1;
        win_alu = 1'b0;
        win_mem = 1'b0;
        if (!s.rst) begin
            if (s.areq && s.mreq) begin
                win_alu = m_last_mem;
                win_mem = !m_last_mem;
            end else begin
                win_alu = s.areq;
                win_mem = s.mreq;
            end
        end
        ga  = win_mem ? s.maddr : s.aaddr;
        gd  = win_mem ? s.mdata : s.adata;
        eff = m_busy;
        if (EARLY && (win_alu || win_mem)) eff[ga] = 1'b0;
        m_stall = !s.rst && s.iv && (eff[s.is1] || eff[s.is2] || (s.iw && eff[s.idst]));
        checkOutput("alu_ready", 32'(bus.alu_ready), 32'(win_alu));
        checkOutput("mem_ready", 32'(bus.mem_ready), 32'(win_mem));
        checkOutput("stall",     32'(bus.stall),     32'(m_stall));
        m_agrant = win_alu;
        m_mgrant = win_mem;
        if (s.rst) begin
            m_busy = 8'h00; m_last_mem = 1'b1; m_we = 1'b0; m_waddr = 3'd0; m_wdata = 16'h0;
        end else begin
            m_we = win_alu || win_mem;
            if (m_we) begin
                m_waddr    = ga;
                m_wdata    = gd;
                m_busy[ga] = 1'b0;
                m_last_mem = win_mem;
            end
            if (s.iv && s.iw && !m_stall) m_busy[s.idst] = 1'b1;
        end
    endtask

    // Registered outputs just after the edge that follows the last step.
    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pickAddr();
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        if (m_busy != 8'h00 && $urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 16; k++) begin
                if (!m_busy[a]) a = 3'($urandom_range(0, 7));
            end
        end
        return a;
    endfunction

    initial begin
        stim_t s;
        logic        ap, mp;
        logic [2:0]  aa, ma;
        logic [15:0] ad, md;

        s = idle();
        s.rst = 1'b1;
        applyStimulus(s);
        m_busy = 8'h00; m_last_mem = 1'b1; m_we = 1'b0; m_waddr = 3'd0; m_wdata = 16'h0;
        m_agrant = 1'b0; m_mgrant = 1'b0; m_stall = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset
        for (int i = 0; i < 5; i++) stepCycle(idle());
        checkOutput("idle_stall", 32'(bus.stall), 32'd0);
        afterEdge();
        checkOutput("idle_busy", 32'(bus.busy_vec), 32'h00);
        checkOutput("idle_we",   32'(bus.rf_we),    32'd0);

        // RAW hazard on r3, then the ALU writes r3
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.idst = 3'd3;
        stepCycle(s);
        afterEdge();
        checkOutput("raw_busy", 32'(bus.busy_vec), 32'h08);
        s = idle(); s.iv = 1'b1; s.is1 = 3'd3;
        stepCycle(s);
        checkOutput("raw_stall", 32'(bus.stall), 32'd1);
        s = idle(); s.areq = 1'b1; s.aaddr = 3'd3; s.adata = 16'h1234;
        stepCycle(s);
        checkOutput("raw_alu_ready", 32'(bus.alu_ready), 32'd1);
        afterEdge();
        checkOutput("raw_we",    32'(bus.rf_we),    32'd1);
        checkOutput("raw_waddr", 32'(bus.rf_waddr), 32'd3);
        checkOutput("raw_wdata", 32'(bus.rf_wdata), 32'h1234);
        checkOutput("raw_clear", 32'(bus.busy_vec), 32'h00);

        // Contention straight after reset: ALU first, then MEM
        s = idle(); s.rst = 1'b1;
        stepCycle(s);
        s = idle(); s.areq = 1'b1; s.aaddr = 3'd1; s.adata = 16'hAAAA;
        s.mreq = 1'b1; s.maddr = 3'd2; s.mdata = 16'h5555;
        stepCycle(s);
        checkOutput("rr1_alu", 32'(bus.alu_ready), 32'd1);
        checkOutput("rr1_mem", 32'(bus.mem_ready), 32'd0);
        afterEdge();
        checkOutput("rr1_waddr", 32'(bus.rf_waddr), 32'd1);
        checkOutput("rr1_wdata", 32'(bus.rf_wdata), 32'hAAAA);
        s.areq = 1'b0;
        stepCycle(s);
        checkOutput("rr2_mem", 32'(bus.mem_ready), 32'd1);
        afterEdge();
        checkOutput("rr2_we",    32'(bus.rf_we),    32'd1);
        checkOutput("rr2_waddr", 32'(bus.rf_waddr), 32'd2);
        checkOutput("rr2_wdata", 32'(bus.rf_wdata), 32'h5555);
        s = idle(); s.areq = 1'b1; s.aaddr = 3'd6; s.adata = 16'h0606;
        s.mreq = 1'b1; s.maddr = 3'd7; s.mdata = 16'h0707;
        stepCycle(s);
        checkOutput("rr3_alu", 32'(bus.alu_ready), 32'd1);
        checkOutput("rr3_mem", 32'(bus.mem_ready), 32'd0);
        s.areq = 1'b0;
        stepCycle(s);

        // Grant clears r5 while a new write to r5 issues: set wins
        s = idle(); s.areq = 1'b1; s.aaddr = 3'd5; s.adata = 16'h0505;
        s.iv = 1'b1; s.iw = 1'b1; s.idst = 3'd5;
        stepCycle(s);
        afterEdge();
        checkOutput("setwins_busy", 32'(bus.busy_vec), 32'h20);

        // Dependent read of r4 in the cycle r4 is granted
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.idst = 3'd4;
        stepCycle(s);
        s = idle(); s.mreq = 1'b1; s.maddr = 3'd4; s.mdata = 16'h4444;
        s.iv = 1'b1; s.is2 = 3'd4;
        stepCycle(s);
        checkOutput("early_stall", 32'(bus.stall), 32'(!EARLY));

        // Fill every register, then reset with an ALU request pending
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.iv = 1'b1; s.iw = 1'b1;
            s.idst = 3'(i); s.is1 = 3'(i); s.is2 = 3'(i);
            stepCycle(s);
        end
        afterEdge();
        checkOutput("full_busy", 32'(bus.busy_vec), 32'hFF);
        s = idle(); s.rst = 1'b1; s.areq = 1'b1; s.aaddr = 3'd2; s.adata = 16'hBEEF;
        stepCycle(s);
        checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        afterEdge();
        checkOutput("rst_busy", 32'(bus.busy_vec), 32'h00);
        checkOutput("rst_we",   32'(bus.rf_we),    32'd0);
        s.rst = 1'b0;
        stepCycle(s);

        // Randomized traffic with protocol-following requesters
        ap = 1'b0; mp = 1'b0; aa = 3'd0; ma = 3'd0; ad = 16'h0; md = 16'h0;
        for (int c = 0; c < 600; c++) begin
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap = 1'b1; aa = pickAddr(); ad = 16'($urandom);
            end
            if (!mp && $urandom_range(0, 2) == 0) begin
                mp = 1'b1; ma = pickAddr(); md = 16'($urandom);
            end
            s = idle();
            s.rst  = ($urandom_range(0, 49) == 0);
            s.areq = ap; s.aaddr = aa; s.adata = ad;
            s.mreq = mp; s.maddr = ma; s.mdata = md;
            s.iv   = 1'($urandom_range(0, 1));
            s.iw   = 1'($urandom_range(0, 1));
            s.idst = 3'($urandom_range(0, 7));
            s.is1  = 3'($urandom_range(0, 7));
            s.is2  = 3'($urandom_range(0, 7));
            stepCycle(s);
            if (m_agrant) ap = 1'b0;
            if (m_mgrant) mp = 1'b0;
        end
        stepCycle(idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
